ps2_key_tracker: RTL and testbench

- Successor to the PS/2 scan-code post-processor.
- Consumes decoded PS/2 scan-code bytes from the PS/2 receiver and decodes make, break (F0) and extended (E0) sequences.
- Tracks up to SLOTS simultaneously held keys, each with its scan code and ASCII translation obtained from an external scan-code ROM (1-cycle read).
- Counts total distinct key presses for the seven-segment display path.

---
 rtl/ps2_key_tracker.sv | 159 +++++++++++++++
 tb/tb_ps2_key_tracker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: decodes make/break/E0 sequences, holds up to SLOTS pressed keys
// with their ASCII from an external scan-code ROM, and counts distinct presses.
module ps2_key_tracker #(
  parameter int SLOTS = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 code_valid,
  input  logic [7:0]           code_data,
  output logic                 code_ready,
  output logic [7:0]           rom_addr,
  input  logic [7:0]           rom_data,
  output logic [SLOTS-1:0]     key_valid,
  output logic [SLOTS-1:0]     key_ext,
  output logic [8*SLOTS-1:0]   key_code,
  output logic [8*SLOTS-1:0]   key_ascii,
  output logic [CNT_W-1:0]     press_count,
  output logic                 overflow
);

  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, LOOKUP} state_t;

  state_t                 state_q, state_d;
  logic [SLOTS-1:0]       valid_q, valid_d, ext_q, ext_d;
  logic [SLOTS-1:0][7:0]  code_q, code_d, ascii_q, ascii_d;
  logic [IDX_W-1:0]       slot_q, slot_d;
  logic [7:0]             rom_addr_q, rom_addr_d;
  logic [CNT_W-1:0]       press_q, press_d;
  logic                   overflow_q, overflow_d;

  logic                   accept, ext_sel, do_make, do_break;
  logic                   match_hit, free_hit;
  logic [IDX_W-1:0]       match_idx, free_idx;
  logic                   is_err;

  always_comb begin
    accept    = code_valid && (state_q != LOOKUP);
    ext_sel   = (state_q == EXT) || (state_q == EXT_BRK);
    is_err    = (code_data == 8'h00) || (code_data == 8'hFF);
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    // Downward scans so the lowest index wins.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (valid_q[i] && ext_q[i] == ext_sel && code_q[i] == code_data) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    ext_d      = ext_q;
    code_d     = code_q;
    ascii_d    = ascii_q;
    slot_d     = slot_q;
    rom_addr_d = rom_addr_q;
    press_d    = press_q;
    overflow_d = overflow_q;
    do_make    = 1'b0;
    do_break   = 1'b0;

    if (valid_q == '0) overflow_d = 1'b0;

    case (state_q)
      IDLE: if (accept) begin
        if (code_data == 8'hE0)      state_d = EXT;
        else if (code_data == 8'hF0) state_d = BRK;
        else if (!is_err)            do_make = 1'b1;
      end
      EXT: if (accept) begin
        if (code_data == 8'hF0)                  state_d = EXT_BRK;
        else if (is_err || code_data == 8'hE0)   state_d = IDLE;
        else                                     do_make = 1'b1;
      end
      BRK, EXT_BRK: if (accept) do_break = 1'b1;
      LOOKUP: begin
        ascii_d[slot_q] = rom_data;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_make) begin
      state_d = IDLE;
      if (!match_hit) begin
        if (free_hit) begin
          valid_d[free_idx] = 1'b1;
          ext_d[free_idx]   = ext_sel;
          code_d[free_idx]  = code_data;
          ascii_d[free_idx] = 8'h00;
          press_d           = press_q + CNT_W'(1);
          slot_d            = free_idx;
          // Address goes out in the accepting cycle so a registered ROM has data during LOOKUP.
          if (!ext_sel) begin
            rom_addr_d = code_data;
            state_d    = LOOKUP;
          end
        end else begin
          overflow_d = 1'b1;
        end
      end
    end

    if (do_break) begin
      state_d = IDLE;
      if (match_hit) begin
        valid_d[match_idx] = 1'b0;
        ext_d[match_idx]   = 1'b0;
        code_d[match_idx]  = 8'h00;
        ascii_d[match_idx] = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      ext_q      <= '0;
      code_q     <= '0;
      ascii_q    <= '0;
      slot_q     <= '0;
      rom_addr_q <= '0;
      press_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ext_q      <= ext_d;
      code_q     <= code_d;
      ascii_q    <= ascii_d;
      slot_q     <= slot_d;
      rom_addr_q <= rom_addr_d;
      press_q    <= press_d;
      overflow_q <= overflow_d;
    end
  end

  assign code_ready  = (state_q != LOOKUP);
  assign rom_addr    = rom_addr_d;
  assign key_valid   = valid_q;
  assign key_ext     = ext_q;
  assign key_code    = code_q;
  assign key_ascii   = ascii_q;
  assign press_count = press_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker (SLOTS=2, CNT_W=8) with a registered scan-code ROM model.
module tb_ps2_key_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        code_valid = 1'b0;
  logic [7:0]  code_data = 8'h00;
  logic        code_ready;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [1:0]  key_valid, key_ext;
  logic [15:0] key_code, key_ascii;
  logic [7:0]  press_count;
  logic        overflow;

  int n_vec = 0;
  int n_bad = 0;

  ps2_key_tracker #(.SLOTS(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code_data(code_data),
    .code_ready(code_ready), .rom_addr(rom_addr), .rom_data(rom_data),
    .key_valid(key_valid), .key_ext(key_ext), .key_code(key_code),
    .key_ascii(key_ascii), .press_count(press_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [7:0] a);
    return (a == 8'h1C) ? 8'h61 : a + 8'h20;
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  typedef struct {
    logic [7:0]  b;
    logic [1:0]  v;
    logic [1:0]  x;
    logic [15:0] code;
    logic [15:0] ascii;
    logic [7:0]  cnt;
    logic        ov;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int k;
    k = 0;
    while (!code_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!code_ready) check("ready_timeout", 64'(code_ready), 64'd1);
    code_valid = 1'b1;
    code_data  = b;
    @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] pack_out();
    return {key_valid, key_ext, key_code, key_ascii, press_count, 3'b000, overflow, 8'h00};
  endfunction

  function automatic logic [63:0] pack_exp(input vec_t e);
    return {e.v, e.x, e.code, e.ascii, e.cnt, 3'b000, e.ov, 8'h00};
  endfunction

  task automatic add(input logic [7:0] b, input logic [1:0] v, input logic [1:0] x,
                     input logic [15:0] c, input logic [15:0] a, input logic [7:0] n,
                     input logic ov);
    vec_t e;
    e.b = b; e.v = v; e.x = x; e.code = c; e.ascii = a; e.cnt = n; e.ov = ov;
    vecs.push_back(e);
  endtask

  initial begin
    vec_t e;

    // held 1C; typematic, break, fill, overflow, refill, stray break, release all
    add(8'h1C, 2'b01, 2'b00, 16'h001C, 16'h0061, 8'd1, 1'b0);
    add(8'h1C, 2'b01, 2'b00, 16'h001C, 16'h0061, 8'd1, 1'b0);
    add(8'hF0, 2'b01, 2'b00, 16'h001C, 16'h0061, 8'd1, 1'b0);
    add(8'h1C, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'd1, 1'b0);
    add(8'h32, 2'b01, 2'b00, 16'h0032, 16'h0052, 8'd2, 1'b0);
    add(8'h1C, 2'b11, 2'b00, 16'h1C32, 16'h6152, 8'd3, 1'b0);
    add(8'h21, 2'b11, 2'b00, 16'h1C32, 16'h6152, 8'd3, 1'b1);
    add(8'hF0, 2'b11, 2'b00, 16'h1C32, 16'h6152, 8'd3, 1'b1);
    add(8'h1C, 2'b01, 2'b00, 16'h0032, 16'h0052, 8'd3, 1'b1);
    add(8'h21, 2'b11, 2'b00, 16'h2132, 16'h4152, 8'd4, 1'b1);
    add(8'hF0, 2'b11, 2'b00, 16'h2132, 16'h4152, 8'd4, 1'b1);
    add(8'h4D, 2'b11, 2'b00, 16'h2132, 16'h4152, 8'd4, 1'b1);
    add(8'hF0, 2'b11, 2'b00, 16'h2132, 16'h4152, 8'd4, 1'b1);
    add(8'h32, 2'b10, 2'b00, 16'h2100, 16'h4100, 8'd4, 1'b1);
    add(8'hF0, 2'b10, 2'b00, 16'h2100, 16'h4100, 8'd4, 1'b1);
    add(8'h21, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'd4, 1'b0);
    add(8'h00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'd4, 1'b0);
    add(8'hFF, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'd4, 1'b0);
    // extended keys
    add(8'hE0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'd4, 1'b0);
    add(8'h75, 2'b01, 2'b01, 16'h0075, 16'h0000, 8'd5, 1'b0);
    add(8'hE0, 2'b01, 2'b01, 16'h0075, 16'h0000, 8'd5, 1'b0);
    add(8'h00, 2'b01, 2'b01, 16'h0075, 16'h0000, 8'd5, 1'b0);
    add(8'hE0, 2'b01, 2'b01, 16'h0075, 16'h0000, 8'd5, 1'b0);
    add(8'h75, 2'b01, 2'b01, 16'h0075, 16'h0000, 8'd5, 1'b0);
    add(8'hE0, 2'b01, 2'b01, 16'h0075, 16'h0000, 8'd5, 1'b0);
    add(8'hF0, 2'b01, 2'b01, 16'h0075, 16'h0000, 8'd5, 1'b0);
    add(8'h75, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'd5, 1'b0);
    // E0 1C and plain 1C are distinct keys
    add(8'hE0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'd5, 1'b0);
    add(8'h1C, 2'b01, 2'b01, 16'h001C, 16'h0000, 8'd6, 1'b0);
    add(8'h1C, 2'b11, 2'b01, 16'h1C1C, 16'h6100, 8'd7, 1'b0);
    add(8'hF0, 2'b11, 2'b01, 16'h1C1C, 16'h6100, 8'd7, 1'b0);
    add(8'h1C, 2'b01, 2'b01, 16'h001C, 16'h0000, 8'd7, 1'b0);
    add(8'hE0, 2'b01, 2'b01, 16'h001C, 16'h0000, 8'd7, 1'b0);
    add(8'hF0, 2'b01, 2'b01, 16'h001C, 16'h0000, 8'd7, 1'b0);
    add(8'h1C, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'd7, 1'b0);

    repeat (2) @(negedge clk);
    check("reset_state", {pack_out(), 7'd0, code_ready}, {64'd0, 8'd1});
    rst_n = 1'b1;
    @(negedge clk);

    // first make: ready drops exactly one cycle, ASCII lands a cycle after the key
    code_valid = 1'b1;
    code_data  = 8'h1C;
    @(posedge clk); #1;
    code_valid = 1'b0;
    check("make_cycle1", {62'd0, code_ready, key_valid[0]}, {62'd0, 1'b0, 1'b1});
    check("ascii_cycle1", 64'(key_ascii), 64'h0);
    check("rom_addr", 64'(rom_addr), 64'h1C);
    @(posedge clk); #1;
    check("make_cycle2", {key_ascii, 8'd0, press_count, 31'd0, code_ready},
          {16'h0061, 8'd0, 8'd1, 31'd0, 1'b1});
    @(negedge clk);

    foreach (vecs[i]) begin
      sb.push_back(vecs[i]);
      send(vecs[i].b);
      e = sb.pop_front();
      check($sformatf("vec%0d_%h", i, e.b), pack_out(), pack_exp(e));
    end

    // asynchronous reset in the middle of a break sequence
    send(8'h1C);
    send(8'hF0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {pack_out(), 7'd0, code_ready}, {64'd0, 8'd1});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h1C);
    check("make_after_reset", pack_out(),
          {2'b01, 2'b00, 16'h001C, 16'h0061, 8'd1, 3'b000, 1'b0, 8'h00});

    // counter wrap
    for (int i = 0; i < 254; i++) begin
      send(8'hF0);
      send(8'h1C);
      send(8'h1C);
    end
    check("count_ff", 64'(press_count), 64'hFF);
    send(8'hF0);
    send(8'h1C);
    send(8'h1C);
    check("count_wrap", {key_valid, 54'd0, press_count}, {2'b01, 54'd0, 8'h00});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
